load_use_stall_ctrl: RTL and testbench

- Generates the five pipeline stall signals, the IF/OF and OF/EX flushes, and the OF/EX bubble-insert for the in-order single-issue RV32 pipeline.
- Resolves three hazards:
  - Load-use, which forwarding cannot cover.
  - Multi-cycle data-memory accesses (req/ready wait states).
  - Taken-branch/jump redirects from EX, including redirects that arrive while the pipe is frozen.
- Sits beside the forwarding unit and drives the stall outputs that the forwarding unit currently ties low. It also keeps saturating hazard performance counters.

---
 rtl/load_use_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_load_use_stall_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_use_stall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_use_stall_ctrl - stall/flush/bubble control for load-use, mem wait, redirects (rev 1.0)
// ----------------------------------------------------------------------------
module load_use_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             of_valid,
  input  logic [4:0]       of_rs1,
  input  logic [4:0]       of_rs2,
  input  logic             of_uses_rs1,
  input  logic             of_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             redirect,
  output logic             stall_if,
  output logic             stall_ifof,
  output logic             stall_ofex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             flush_ifof,
  output logic             flush_ofex,
  output logic             bubble_ofex,
  output logic [1:0]       hazard_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int                WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01
  } state_t;

  state_t            state_q, state_d;
  logic              redir_pend_q, redir_pend_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic rs1_hit, rs2_hit;
  logic lu, mw, redir_eff;
  logic run_eval;
  logic freeze, flush, bubble_evt;

  assign rs1_hit   = of_uses_rs1 && (of_rs1 == ex_rd);
  assign rs2_hit   = of_uses_rs2 && (of_rs2 == ex_rd);
  assign lu        = of_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign mw        = mem_req && !mem_ready;
  assign redir_eff = redirect || redir_pend_q;

  // The release cycle of a memory wait is evaluated exactly like a RUN cycle.
  assign run_eval = (state_q == ST_RUN) ? !mw : mem_ready;

  always_comb begin
    state_d       = state_q;
    redir_pend_d  = redir_pend_q;
    wait_d        = wait_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    flush         = 1'b0;
    bubble_evt    = 1'b0;

    if (run_eval) begin
      state_d = ST_RUN;
      if (redir_eff) begin
        flush        = 1'b1;
        redir_pend_d = 1'b0;
      end else if (lu) begin
        bubble_evt = 1'b1;
      end
    end else begin
      freeze = 1'b1;
      if (redirect) begin
        redir_pend_d = 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end
        ST_MEM_WAIT: begin
          if (wait_q != C_WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
          end
          if (wait_d == C_WAIT_MAX) begin
            mem_timeout_d = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((freeze || bubble_evt) && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bubble_evt && (bubble_cnt_q != C_CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      redir_pend_q  <= 1'b0;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      redir_pend_q  <= redir_pend_d;
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, whatever the inputs do.
  always_comb begin
    stall_if    = 1'b0;
    stall_ifof  = 1'b0;
    stall_ofex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_ifof  = 1'b0;
    flush_ofex  = 1'b0;
    bubble_ofex = 1'b0;
    if (resetn) begin
      stall_if    = freeze || bubble_evt;
      stall_ifof  = freeze || bubble_evt;
      stall_ofex  = freeze;
      stall_exmem = freeze;
      stall_memwb = freeze;
      flush_ifof  = flush;
      flush_ofex  = flush;
      bubble_ofex = bubble_evt;
    end
  end

  assign hazard_state = state_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign bubble_count = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_load_use_stall_ctrl.sv
`default_nettype none
// tb_load_use_stall_ctrl - directed and randomized checks against a rule-level hazard model.
module tb_load_use_stall_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          of_valid, of_uses_rs1, of_uses_rs2, ex_valid, ex_is_load;
  logic [4:0]    of_rs1, of_rs2, ex_rd;
  logic          mem_req, mem_ready, redirect;
  logic          stall_if, stall_ifof, stall_ofex, stall_exmem, stall_memwb;
  logic          flush_ifof, flush_ofex, bubble_ofex, mem_timeout;
  logic [1:0]    hazard_state;
  logic [CW-1:0] stall_cycles, bubble_count;
  logic [7:0]    out_vec;

  int n_chk = 0;
  int n_err = 0;

  // Model state: frozen pipe, pending redirect, wait cycles, timeout flag, counters.
  bit m_frozen, m_pend, m_to;
  int m_wait, m_stalls, m_bubbles;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_uses_rs1(of_uses_rs1), .of_uses_rs2(of_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_ready(mem_ready), .redirect(redirect),
    .stall_if(stall_if), .stall_ifof(stall_ifof), .stall_ofex(stall_ofex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifof(flush_ifof), .flush_ofex(flush_ofex), .bubble_ofex(bubble_ofex),
    .hazard_state(hazard_state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  assign out_vec = {stall_if, stall_ifof, stall_ofex, stall_exmem, stall_memwb,
                    flush_ifof, flush_ofex, bubble_ofex};

  function automatic bit m_lu();
    if (!(of_valid && ex_valid && ex_is_load) || ex_rd == 5'd0) return 1'b0;
    return (of_uses_rs1 && of_rs1 == ex_rd) || (of_uses_rs2 && of_rs2 == ex_rd);
  endfunction

  // True when this cycle obeys the free-running rules (not frozen by memory).
  function automatic bit m_runs();
    return m_frozen ? mem_ready : !(mem_req && !mem_ready);
  endfunction

  function automatic logic [7:0] m_out();
    if (!resetn) return 8'h00;
    if (!m_runs()) return 8'b11111_000;
    if (redirect || m_pend) return 8'b00000_110;
    if (m_lu()) return 8'b11000_001;
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_frozen = 0; m_pend = 0; m_to = 0;
    m_wait = 0; m_stalls = 0; m_bubbles = 0;
  endtask

  task automatic m_step();
    logic [7:0] o;
    o = m_out();
    if (o[7] && m_stalls < CMAX) m_stalls++;
    if (o[0] && m_bubbles < CMAX) m_bubbles++;
    if (!m_runs()) begin
      if (redirect) m_pend = 1;
      if (m_frozen) begin
        if (m_wait < TO) m_wait++;
        if (m_wait == TO) m_to = 1;
      end else begin
        m_frozen = 1;
        m_wait   = 0;
      end
    end else begin
      m_frozen = 0;
      m_pend   = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    of_valid = 0; of_uses_rs1 = 0; of_uses_rs2 = 0; of_rs1 = 0; of_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0;
    mem_req = 0; mem_ready = 0; redirect = 0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs2);
    of_valid = 1; of_uses_rs1 = 1; of_rs1 = 5'd31; of_uses_rs2 = 1; of_rs2 = rs2;
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic test_reset();
    idle();
    load_use(5'd5, 5'd5);
    mem_req = 1; redirect = 1;
    resetn = 0;
    m_reset();
    @(posedge clk);
    #2;
    n_chk++;
    if (out_vec !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs: got %b want 00000000", out_vec);
    end
    n_chk++;
    if ({stall_cycles, bubble_count, hazard_state, mem_timeout} !== '0) begin
      n_err++; $display("FAIL reset_regs: got cnt=%0d bub=%0d st=%b to=%b want all 0",
                        stall_cycles, bubble_count, hazard_state, mem_timeout);
    end
    idle();
    #1 resetn = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      if (i == 0) load_use(5'd5, 5'd5);
      #1;
      n_chk++;
      if (out_vec !== m_out()) begin
        n_err++; $display("FAIL load_use_c%0d: outputs got %b want %b", i, out_vec, m_out());
      end
      tick();
      n_chk++;
      if (bubble_count !== CW'(m_bubbles) || stall_cycles !== CW'(m_stalls)) begin
        n_err++; $display("FAIL load_use_cnt_c%0d: bub=%0d stl=%0d want bub=%0d stl=%0d",
                          i, bubble_count, stall_cycles, m_bubbles, m_stalls);
      end
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      mem_req   = (i <= 3);
      mem_ready = (i == 3);
      #1;
      n_chk++;
      if (out_vec !== m_out()) begin
        n_err++; $display("FAIL mem_wait_c%0d: outputs got %b want %b", i, out_vec, m_out());
      end
      tick();
      n_chk++;
      if (hazard_state !== 2'(m_frozen) || stall_cycles !== CW'(m_stalls)) begin
        n_err++; $display("FAIL mem_wait_reg_c%0d: st=%b stl=%0d want st=%0d stl=%0d",
                          i, hazard_state, stall_cycles, m_frozen, m_stalls);
      end
    end
  endtask

  task automatic test_redirect_in_wait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      mem_req   = (i <= 4);
      mem_ready = (i == 4);
      redirect  = (i == 1);
      if (i == 4) load_use(5'd7, 5'd7);
      #1;
      n_chk++;
      if (out_vec !== m_out()) begin
        n_err++; $display("FAIL redir_wait_c%0d: outputs got %b want %b", i, out_vec, m_out());
      end
      tick();
      n_chk++;
      if (hazard_state !== 2'(m_frozen) || bubble_count !== CW'(m_bubbles)) begin
        n_err++; $display("FAIL redir_wait_reg_c%0d: st=%b bub=%0d want st=%0d bub=%0d",
                          i, hazard_state, bubble_count, m_frozen, m_bubbles);
      end
    end
  endtask

  task automatic test_redirect_and_lu();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin load_use(5'd9, 5'd9); redirect = 1; end
        1: begin load_use(5'd0, 5'd0); of_rs1 = 5'd0; end
        default: load_use(5'd3, 5'd4);
      endcase
      #1;
      n_chk++;
      if (out_vec !== m_out()) begin
        n_err++; $display("FAIL redir_lu_c%0d: outputs got %b want %b", i, out_vec, m_out());
      end
      tick();
      n_chk++;
      if (bubble_count !== CW'(m_bubbles)) begin
        n_err++; $display("FAIL redir_lu_bub_c%0d: got %0d want %0d", i, bubble_count, m_bubbles);
      end
    end
  endtask

  task automatic test_timeout_and_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      mem_req   = (i != 7);
      mem_ready = (i == 6);
      #1;
      n_chk++;
      if (out_vec !== m_out()) begin
        n_err++; $display("FAIL timeout_c%0d: outputs got %b want %b", i, out_vec, m_out());
      end
      tick();
      n_chk++;
      if (mem_timeout !== m_to || hazard_state !== 2'(m_frozen)) begin
        n_err++; $display("FAIL timeout_reg_c%0d: to=%b st=%b want to=%0d st=%0d",
                          i, mem_timeout, hazard_state, m_to, m_frozen);
      end
    end
    // Cycles 8 and 9 started a new wait; drop reset in the middle of it.
    idle();
    mem_req = 1;
    #2 resetn = 0;
    m_reset();
    #1;
    n_chk++;
    if (out_vec !== 8'h00 ||
        {stall_cycles, bubble_count, hazard_state, mem_timeout} !== '0) begin
      n_err++; $display("FAIL async_reset: out=%b cnt=%0d bub=%0d st=%b to=%b want all 0",
                        out_vec, stall_cycles, bubble_count, hazard_state, mem_timeout);
    end
    @(posedge clk);
    idle();
    #1 resetn = 1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 42; i++) begin
      idle();
      if (i < 20) begin
        mem_req = 1;
      end else if (i == 20) begin
        mem_req = 1; mem_ready = 1;
      end else begin
        load_use(5'd12, 5'd12);
      end
      #1;
      n_chk++;
      if (out_vec !== m_out()) begin
        n_err++; $display("FAIL saturate_c%0d: outputs got %b want %b", i, out_vec, m_out());
      end
      tick();
      n_chk++;
      if (stall_cycles !== CW'(m_stalls) || bubble_count !== CW'(m_bubbles)) begin
        n_err++; $display("FAIL saturate_cnt_c%0d: stl=%0d bub=%0d want stl=%0d bub=%0d",
                          i, stall_cycles, bubble_count, m_stalls, m_bubbles);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      of_valid    = ($urandom_range(0, 3) != 0);
      of_uses_rs1 = $urandom_range(0, 1);
      of_uses_rs2 = $urandom_range(0, 1);
      of_rs1      = 5'($urandom_range(0, 3));
      of_rs2      = 5'($urandom_range(0, 3));
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_is_load  = $urandom_range(0, 1);
      ex_rd       = 5'($urandom_range(0, 3));
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = $urandom_range(0, 1);
      redirect    = ($urandom_range(0, 7) == 0);
      #1;
      n_chk++;
      if (out_vec !== m_out()) begin
        n_err++; $display("FAIL random_c%0d: outputs got %b want %b", i, out_vec, m_out());
      end
      n_chk++;
      if (stall_ifof > stall_if || stall_ofex > stall_ifof || stall_exmem > stall_ofex ||
          stall_memwb > stall_exmem || (stall_ifof && (flush_ifof || flush_ofex))) begin
        n_err++; $display("FAIL random_chain_c%0d: outputs got %b want chained stalls", i, out_vec);
      end
      tick();
      n_chk++;
      if ({stall_cycles, bubble_count, hazard_state, mem_timeout} !==
          {CW'(m_stalls), CW'(m_bubbles), 2'(m_frozen), m_to}) begin
        n_err++; $display("FAIL random_reg_c%0d: stl=%0d bub=%0d st=%b to=%b want %0d %0d %0d %0d",
                          i, stall_cycles, bubble_count, hazard_state, mem_timeout,
                          m_stalls, m_bubbles, m_frozen, m_to);
      end
    end
  endtask

  initial begin
    idle();
    m_reset();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect_in_wait();
    test_redirect_and_lu();
    test_timeout_and_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
